fifo_uart_drain: RTL
====================

Name: fifo_uart_drain

Overview:
Consumer end of the byte FIFO. Pops bytes from the FIFO whenever it is non-empty and enabled, then serialises each byte onto a UART TX line (8N1 by default, LSB first) for the BASYS3 USB-UART bridge. It sits downstream of fifo and drives its read side: Empty in, read out, re_data in.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range 2..65535
DATA_W, 8, bits per frame payload; must match the FIFO data width
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
clk  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
enable  input  1  1 = allowed to start popping new bytes
fifo_empty  input  1  connects to FIFO Empty
fifo_data  input  DATA_W  connects to FIFO re_data; valid the cycle after fifo_rd
fifo_rd  output  1  one-cycle read strobe to FIFO read
tx  output  1  UART serial out; idle high
busy  output  1  1 from the pop cycle through the end of the last stop bit
byte_done  output  1  one-cycle pulse in the final cycle of the last stop bit

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE, tx=1, fifo_rd=0, busy=0, byte_done=0, bit and baud counters cleared. All outputs are registered.
- IDLE: tx=1. If enable=1 and fifo_empty=0, go to POP. Otherwise stay.
- POP: fifo_rd=1 for exactly this one cycle; busy=1; next state is LOAD.
- LOAD: capture fifo_data into the shift register; reset the baud counter; next state is START.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit; after DATA_W bits go to STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. byte_done=1 in the last cycle. Then go to IDLE, or go directly to POP if enable=1 and fifo_empty=0.
- Timing: frame on the wire = (1+DATA_W+STOP_BITS)*CLKS_PER_BIT cycles.
  - First tx falling edge is 3 cycles after IDLE samples non-empty (POP, LOAD, then START registered).
  - Back-to-back frames have exactly 2 extra idle-high cycles (POP, LOAD) between stop and start.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps; its width is clog2(CLKS_PER_BIT). Bit index is clog2(DATA_W+1) bits wide.
- fifo_rd is never asserted while fifo_empty=1 (no underflow). fifo_rd is never asserted outside POP.
- enable dropped mid-frame: the current frame completes normally; no further pop.
- fifo_empty rising mid-frame: no effect on the current frame.
- Reset mid-frame: tx returns high at the next edge. The partial byte is discarded and the FIFO is not re-read.
- Reset during POP: the pop has already occurred and that byte is lost; this is accepted.
- Illegal or unreachable state encoding: return to IDLE with tx=1.

Decomposition:
- Package fifo_uart_pkg:
  - State encoding (IDLE, POP, LOAD, START, DATA, STOP) as 3-bit localparams.
  - Default CLKS_PER_BIT.
  - UART idle/start/stop level constants.
- Sub-module baud_tick_gen:
  - Parameter CLKS_PER_BIT.
  - Inputs clk, reset, clear.
  - Output tick, a one-cycle pulse each CLKS_PER_BIT cycles after clear.
  - Reused later by the receiver.

Test Plan:
- CLKS_PER_BIT=4, FIFO preloaded with 0x47, enable=1 -> one fifo_rd pulse; tx sequence per 4 cycles: 0,1,1,1,0,0,0,1,0,1; byte_done at cycle 40 of the frame; busy=0 afterwards; no second fifo_rd.
- FIFO holding 0xA5 then 0x3C, enable=1 -> two frames (0xA5 bits 1,0,1,0,0,1,0,1; 0x3C bits 0,0,1,1,1,1,0,0); exactly 2 high cycles between the stop end and the next start; exactly 2 fifo_rd pulses.
- fifo_empty=1, enable=1 for 200 cycles -> fifo_rd never 1, tx constant 1, busy 0.
- enable dropped during the DATA bit 3 of 0x55 with a second byte queued -> 0x55 completes, fifo_rd stays 0, tx stays high.
- reset=0 for one cycle during bit 5 of 0xFF -> tx=1 next cycle, state IDLE, busy=0; after release with the FIFO non-empty, the new frame starts cleanly with a full start bit.
- STOP_BITS=2, byte 0x00 -> 8 low data bits after the start bit, then 8 high cycles before byte_done.

Source files
------------

// File: rtl/fifo_uart_drain_pkg.sv
// ============================================================================
// fifo_uart_pkg : shared state encoding and UART line levels for the drain.
// Revision      : 1.0
// ============================================================================
`default_nettype none

package fifo_uart_pkg;

    localparam logic [2:0] C_ST_IDLE  = 3'd0;
    localparam logic [2:0] C_ST_POP   = 3'd1;
    localparam logic [2:0] C_ST_LOAD  = 3'd2;
    localparam logic [2:0] C_ST_START = 3'd3;
    localparam logic [2:0] C_ST_DATA  = 3'd4;
    localparam logic [2:0] C_ST_STOP  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = C_ST_IDLE,
        S_POP   = C_ST_POP,
        S_LOAD  = C_ST_LOAD,
        S_START = C_ST_START,
        S_DATA  = C_ST_DATA,
        S_STOP  = C_ST_STOP
    } state_t;

    localparam int C_CLKS_PER_BIT_DEFAULT = 868;

    localparam logic C_UART_IDLE  = 1'b1;
    localparam logic C_UART_START = 1'b0;
    localparam logic C_UART_STOP  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/fifo_uart_drain_if.sv
// ============================================================================
// fifo_uart_drain_if : FIFO read-side bundle (empty flag, read data, strobe).
// Revision           : 1.0
// ============================================================================
`default_nettype none

interface fifo_uart_drain_if #(
    parameter int DATA_W = 8
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_rd;

    modport master (input fifo_empty, input fifo_data, output fifo_rd);
    modport slave  (output fifo_empty, output fifo_data, input fifo_rd);
endinterface

`default_nettype wire

// File: rtl/fifo_uart_drain_baud_tick_gen.sv
// ============================================================================
// baud_tick_gen : tick every CLKS_PER_BIT cycles after clear, plus a pre-tick
//                 one cycle earlier. Revision 1.0
// ============================================================================
`default_nettype none

module baud_tick_gen
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = C_CLKS_PER_BIT_DEFAULT
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clear,
    output logic      tick,
    output logic      pre_tick
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] C_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clear || (r_cnt == C_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // pre_tick lets the owner register a strobe that lands on the tick cycle
    assign tick     = !clear && (r_cnt == C_LAST);
    assign pre_tick = !clear && (r_cnt == C_PRE);

endmodule

`default_nettype wire

// File: rtl/fifo_uart_drain.sv
// ============================================================================
// fifo_uart_drain : pops bytes from the FIFO and sends them as UART frames.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module fifo_uart_drain
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = C_CLKS_PER_BIT_DEFAULT,
    parameter int DATA_W       = 8,
    parameter int STOP_BITS    = 1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          enable,
    fifo_uart_drain_if.master  fifo,
    output logic               tx,
    output logic               busy,
    output logic               byte_done
);
    localparam int IDX_W = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0] C_LAST_BIT  = IDX_W'(DATA_W - 1);
    localparam logic [1:0]       C_LAST_STOP = 2'(STOP_BITS - 1);

    state_t            r_state;
    logic [DATA_W-1:0] r_shift;
    logic [IDX_W-1:0]  r_bit_idx;
    logic [1:0]        r_stop_cnt;
    logic              r_tx;
    logic              r_fifo_rd;
    logic              r_busy;
    logic              r_byte_done;

    logic w_clear;
    logic w_tick;
    logic w_pre_tick;
    logic w_start_ok;
    logic w_last_stop;

    assign w_clear     = (r_state == S_LOAD);
    assign w_start_ok  = enable && !fifo.fifo_empty;
    assign w_last_stop = (r_stop_cnt == C_LAST_STOP);

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_clear),
        .tick     (w_tick),
        .pre_tick (w_pre_tick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_stop_cnt  <= '0;
            r_tx        <= C_UART_IDLE;
            r_fifo_rd   <= 1'b0;
            r_busy      <= 1'b0;
            r_byte_done <= 1'b0;
        end else begin
            r_fifo_rd   <= 1'b0;
            r_byte_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx <= C_UART_IDLE;
                    if (w_start_ok) begin
                        r_state   <= S_POP;
                        r_fifo_rd <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_POP: r_state <= S_LOAD;
                // FIFO read data is valid the cycle after the strobe
                S_LOAD: begin
                    r_shift    <= fifo.fifo_data;
                    r_bit_idx  <= '0;
                    r_stop_cnt <= '0;
                    r_tx       <= C_UART_START;
                    r_state    <= S_START;
                end
                S_START: begin
                    if (w_tick) begin
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == C_LAST_BIT) begin
                            r_tx    <= C_UART_STOP;
                            r_state <= S_STOP;
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                        end
                    end
                end
                S_STOP: begin
                    if (w_pre_tick && w_last_stop) begin
                        r_byte_done <= 1'b1;
                    end
                    if (w_tick) begin
                        if (!w_last_stop) begin
                            r_stop_cnt <= r_stop_cnt + 2'd1;
                        end else if (w_start_ok) begin
                            r_state   <= S_POP;
                            r_fifo_rd <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= C_UART_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo.fifo_rd = r_fifo_rd;
    assign tx           = r_tx;
    assign busy         = r_busy;
    assign byte_done    = r_byte_done;

endmodule

`default_nettype wire
